// File: rtl/serial_subtractor_pkg.sv
// Shared types and helpers for the bit-serial subtractor.
package serial_sub_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } sub_state_t;

    // Bit counter width: counts 0 .. WIDTH-1.
    function automatic int cnt_w(input int width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/serial_subtractor_fs.sv
// One-bit full subtractor cell: x - y - bin.
module full_subtractor (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);

    // Difference bit and borrow out; borrow when y (plus incoming borrow) exceeds x.
    always_comb begin
        d    = x ^ y ^ bin;
        bout = (~x & y) | (~(x ^ y) & bin);
    end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b, one bit per clock, LSB first,
// with valid/ready handshakes on both operand and result sides.
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             ovf
);

    localparam int CW = cnt_w(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    sub_state_t       state_q, state_d;
    logic [WIDTH-1:0] sa_q, sa_d;
    logic [WIDTH-1:0] sb_q, sb_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             br_q, br_d;
    logic             amsb_q, amsb_d;
    logic             bmsb_q, bmsb_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             borrow_q, borrow_d;
    logic             ovf_q, ovf_d;
    logic             rdy_q;

    logic d_bit;
    logic bout;

    full_subtractor u_fs (
        .x    (sa_q[0]),
        .y    (sb_q[0]),
        .bin  (br_q),
        .d    (d_bit),
        .bout (bout)
    );

    // rdy_q keeps in_ready low during reset without a path from rst to the output.
    assign in_ready  = (state_q == IDLE) && rdy_q;
    assign out_valid = (state_q == DONE);
    assign diff      = diff_q;
    assign borrow    = borrow_q;
    assign ovf       = ovf_q;

    // Next-state and datapath: load on accept, shift one bit per cycle, publish on last bit.
    always_comb begin
        state_d  = state_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        res_d    = res_q;
        cnt_d    = cnt_q;
        br_d     = br_q;
        amsb_d   = amsb_q;
        bmsb_d   = bmsb_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
        ovf_d    = ovf_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid && rdy_q) begin
                    sa_d    = a;
                    sb_d    = b;
                    amsb_d  = a[WIDTH-1];
                    bmsb_d  = b[WIDTH-1];
                    br_d    = 1'b0;
                    cnt_d   = '0;
                    res_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                sa_d  = sa_q >> 1;
                sb_d  = sb_q >> 1;
                res_d = {d_bit, res_q[WIDTH-1:1]};
                br_d  = bout;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    // Final bit lands now; the output registers hold it until the next result.
                    diff_d   = {d_bit, res_q[WIDTH-1:1]};
                    borrow_d = bout;
                    ovf_d    = (amsb_q != bmsb_q) && (d_bit != amsb_q);
                    state_d  = DONE;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset discards any in-flight operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            sa_q     <= '0;
            sb_q     <= '0;
            res_q    <= '0;
            cnt_q    <= '0;
            br_q     <= 1'b0;
            amsb_q   <= 1'b0;
            bmsb_q   <= 1'b0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            ovf_q    <= 1'b0;
            rdy_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            res_q    <= res_d;
            cnt_q    <= cnt_d;
            br_q     <= br_d;
            amsb_q   <= amsb_d;
            bmsb_q   <= bmsb_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
            ovf_q    <= ovf_d;
            rdy_q    <= 1'b1;
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Randomized and directed bench for serial_subtractor (WIDTH=8).
module tb_serial_subtractor;

    localparam int W   = 8;
    localparam int LIM = 60;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a, b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] diff;
    logic         borrow;
    logic         ovf;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .borrow    (borrow),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: plain integer arithmetic on unsigned and signed views.
    task automatic model(input logic [W-1:0] xa, input logic [W-1:0] xb,
                         output logic [W-1:0] d, output logic bo, output logic ov);
        int ua, ub, sa, sb, sd;
        ua = int'(xa);
        ub = int'(xb);
        sa = (ua >= 128) ? ua - 256 : ua;
        sb = (ub >= 128) ? ub - 256 : ub;
        sd = sa - sb;
        d  = W'((ua - ub + 256) % 256);
        bo = (ua < ub);
        ov = (sd > 127) || (sd < -128);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accept one op, check latency and result; leaves out_ready as the caller set it.
    task automatic do_op(input string tag, input logic [W-1:0] xa, input logic [W-1:0] xb);
        int n, acc;
        logic [W-1:0] ed;
        logic eb, eo;
        n = 0;
        while (!in_ready && n < LIM) begin tick(); n++; end
        chk({tag, "_rdy_tmo"}, (n >= LIM), 0);
        a = xa; b = xb; in_valid = 1'b1;
        tick();
        acc = cyc;
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < LIM) begin tick(); n++; end
        chk({tag, "_vld_tmo"}, (n >= LIM), 0);
        chk({tag, "_latency"}, cyc - acc, W);
        model(xa, xb, ed, eb, eo);
        chk({tag, "_diff"}, diff, ed);
        chk({tag, "_borrow"}, borrow, eb);
        chk({tag, "_ovf"}, ovf, eo);
    endtask

    logic [W-1:0] qa[$], qb[$];

    initial begin
        logic [W-1:0] hold_d, ed;
        logic hold_b, hold_o, eb, eo;
        int pulses, n, prev, acc;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0;

        // Reset state.
        repeat (3) tick();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_diff", diff, 0);
        chk("rst_borrow", borrow, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_in_ready", in_ready, 0);
        rst = 1'b0;
        tick();
        chk("rel_in_ready", in_ready, 1);

        // Directed arithmetic cases.
        do_op("plain", 8'd200, 8'd55);
        chk("plain_abs", diff, 145);
        do_op("under", 8'd10, 8'd20);
        chk("under_abs", {borrow, diff}, 9'h1F6);
        do_op("ovf1", 8'h80, 8'h01);
        chk("ovf1_abs", {ovf, borrow, diff}, 10'h27F);
        do_op("ovf2", 8'h7F, 8'hFF);
        chk("ovf2_abs", {ovf, borrow, diff}, 10'h380);

        // Reset mid-SHIFT: op discarded, outputs cleared, no valid pulse.
        tick();
        a = 8'h33; b = 8'h11; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (4) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_diff", diff, 0);
        chk("mid_rst_in_ready", in_ready, 0);
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            if (out_valid) pulses++;
            tick();
        end
        chk("mid_rst_pulses", pulses, 0);
        chk("mid_rst_idle_ready", in_ready, 1);

        // Backpressure in DONE with ignored in_valid pulses.
        out_ready = 1'b0;
        do_op("bp", 8'h3C, 8'h15);
        hold_d = diff; hold_b = borrow; hold_o = ovf;
        for (int i = 0; i < 5; i++) begin
            a = 8'd1; b = 8'd1; in_valid = i[0];
            tick();
            chk("bp_valid", out_valid, 1);
            chk("bp_ready", in_ready, 0);
            chk("bp_stable", {ovf, borrow, diff}, {hold_o, hold_b, hold_d});
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("bp_release_valid", out_valid, 0);
        chk("bp_release_ready", in_ready, 1);
        chk("bp_keep_diff", diff, hold_d);
        do_op("bp_next", 8'h5A, 8'h5A);

        // Throughput: in_valid and out_ready held high.
        tick();
        in_valid = 1'b1;
        prev = 0;
        for (int i = 0; i < 20; i++) begin
            n = 0;
            while (!in_ready && n < LIM) begin
                if (out_valid && qa.size() > 0) begin
                    model(qa[0], qb[0], ed, eb, eo);
                    chk("tp_res", {ovf, borrow, diff}, {eo, eb, ed});
                    void'(qa.pop_front()); void'(qb.pop_front());
                end
                tick(); n++;
            end
            chk("tp_rdy_tmo", (n >= LIM), 0);
            a = W'($urandom); b = W'($urandom);
            qa.push_back(a); qb.push_back(b);
            acc = cyc + 1;
            if (i > 0) chk("tp_spacing", acc - prev, W + 2);
            prev = acc;
            tick();
        end
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < LIM) begin tick(); n++; end
        chk("tp_last_tmo", (n >= LIM), 0);
        if (qa.size() > 0) begin
            model(qa[0], qb[0], ed, eb, eo);
            chk("tp_res_last", {ovf, borrow, diff}, {eo, eb, ed});
            void'(qa.pop_front()); void'(qb.pop_front());
        end
        chk("tp_drained", qa.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
